// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//
// Shares one single-port, synchronous block RAM (one cycle of read latency)
// between a CPU port (read/write) and a video-fetch port (read only).
// Video has fixed priority. A wait counter forces a CPU win after MAX_WAIT
// consecutive lost decisions, so the CPU cannot starve.
//
// Ports:
//   clock_i, reset_i        single clock, synchronous active-high reset
//   cpu_req_i .. cpu_wdata_i CPU request level and its held address/we/data
//   cpu_ack_o, cpu_rdata_o  CPU one-cycle completion pulse and held read data
//   vid_req_i, vid_addr_i   video read request level and address
//   vid_ack_o, vid_rdata_o  video one-cycle completion pulse and held read data
//   ram_clken_o .. ram_data_o registered RAM port controls
//   ram_q_i                 RAM output, valid the cycle after an enabled access
//
// Every granted access occupies its port for three more decision edges
// (the grant-cycle, q and ack-cycle edges). One access per port can be in
// flight, so the two-stage owner tag pipeline never carries two accesses
// from the same port.
module ram_port_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              vid_req_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  output logic              vid_ack_o,
  output logic [DATA_W-1:0] vid_rdata_o,
  output logic              ram_clken_o,
  output logic              ram_wren_o,
  output logic [ADDR_W-1:0] ram_address_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_q_i
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
  localparam logic [1:0] PEND_EDGES = 2'd3;

  // Saturating increment of the CPU wait counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v >= WAIT_MAX) begin
      return WAIT_MAX;
    end
    return v + 4'd1;
  endfunction

  logic [1:0]        cpu_pend_q, cpu_pend_d;
  logic [1:0]        vid_pend_q, vid_pend_d;
  logic [3:0]        wait_q, wait_d;
  logic              cpu_elig, vid_elig, cpu_win, vid_win;

  logic              ram_clken_q, ram_clken_d;
  logic              ram_wren_q, ram_wren_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;

  // Owner tag pipeline: own = 1 means the access belongs to the CPU.
  logic              vld_p0_q, own_p0_q;
  logic              vld_p1_q, own_p1_q;

  logic              cpu_ack_q, vid_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q, vid_rdata_q;

  // Decision stage: eligibility, priority, wait counter, RAM controls.
  always_comb begin
    cpu_elig   = cpu_req_i && (cpu_pend_q == 2'd0);
    vid_elig   = vid_req_i && (vid_pend_q == 2'd0);
    cpu_win    = cpu_elig && (!vid_elig || (wait_q == WAIT_MAX));
    vid_win    = vid_elig && !cpu_win;

    cpu_pend_d = (cpu_pend_q != 2'd0) ? cpu_pend_q - 2'd1 : 2'd0;
    vid_pend_d = (vid_pend_q != 2'd0) ? vid_pend_q - 2'd1 : 2'd0;
    if (cpu_win) begin
      cpu_pend_d = PEND_EDGES;
    end
    if (vid_win) begin
      vid_pend_d = PEND_EDGES;
    end

    // Counter only runs while the CPU is eligible and being beaten.
    if (!cpu_elig || cpu_win) begin
      wait_d = 4'd0;
    end else begin
      wait_d = sat_inc(wait_q);
    end

    ram_clken_d   = cpu_win || vid_win;
    ram_wren_d    = cpu_win && cpu_we_i;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    if (cpu_win) begin
      ram_address_d = cpu_addr_i;
      ram_data_d    = cpu_wdata_i;
    end else if (vid_win) begin
      ram_address_d = vid_addr_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cpu_pend_q    <= 2'd0;
      vid_pend_q    <= 2'd0;
      wait_q        <= 4'd0;
      ram_clken_q   <= 1'b0;
      ram_wren_q    <= 1'b0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      vld_p0_q      <= 1'b0;
      own_p0_q      <= 1'b0;
      vld_p1_q      <= 1'b0;
      own_p1_q      <= 1'b0;
      cpu_ack_q     <= 1'b0;
      vid_ack_q     <= 1'b0;
      cpu_rdata_q   <= '0;
      vid_rdata_q   <= '0;
    end else begin
      cpu_pend_q    <= cpu_pend_d;
      vid_pend_q    <= vid_pend_d;
      wait_q        <= wait_d;
      // Stage p0: grant cycle, RAM samples the access at its end.
      ram_clken_q   <= ram_clken_d;
      ram_wren_q    <= ram_wren_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      vld_p0_q      <= ram_clken_d;
      own_p0_q      <= cpu_win;
      // Stage p1: ram_q is valid for the tagged owner.
      vld_p1_q      <= vld_p0_q;
      own_p1_q      <= own_p0_q;
      // Completion: latch q into the owner's rdata and pulse its ack.
      cpu_ack_q     <= vld_p1_q && own_p1_q;
      vid_ack_q     <= vld_p1_q && !own_p1_q;
      if (vld_p1_q && own_p1_q) begin
        cpu_rdata_q <= ram_q_i;
      end
      if (vld_p1_q && !own_p1_q) begin
        vid_rdata_q <= ram_q_i;
      end
    end
  end

  assign cpu_ack_o     = cpu_ack_q;
  assign cpu_rdata_o   = cpu_rdata_q;
  assign vid_ack_o     = vid_ack_q;
  assign vid_rdata_o   = vid_rdata_q;
  assign ram_clken_o   = ram_clken_q;
  assign ram_wren_o    = ram_wren_q;
  assign ram_address_o = ram_address_q;
  assign ram_data_o    = ram_data_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int MW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_ack;
  logic [DW-1:0] vid_rdata;
  logic          ram_clken, ram_wren;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q = '0;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clock_i(clk), .reset_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
    .vid_req_i(vid_req), .vid_addr_i(vid_addr), .vid_ack_o(vid_ack),
    .vid_rdata_o(vid_rdata), .ram_clken_o(ram_clken), .ram_wren_o(ram_wren),
    .ram_address_o(ram_address), .ram_data_o(ram_data), .ram_q_i(ram_q)
  );

  // Block RAM: write-through, one cycle read latency.
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) ram_mem[i] = '0;
  always @(posedge clk) begin
    if (ram_clken) begin
      if (ram_wren) begin
        ram_mem[ram_address] <= ram_data;
        ram_q <= ram_data;
      end else begin
        ram_q <= ram_mem[ram_address];
      end
    end
  end

  // Reference model: each port remembers the edge of its last grant and the
  // value that grant returns; everything else follows from edge arithmetic.
  int            edge_n = 0;
  int            m_ge [2];
  bit            m_gv [2];
  logic [DW-1:0] m_val [2];
  logic [DW-1:0] m_mem [0:(1<<AW)-1];
  int            m_wait = 0;
  logic          e_cpu_ack = 0, e_vid_ack = 0, e_clken = 0, e_wren = 0;
  logic [DW-1:0] e_cpu_rdata = '0, e_vid_rdata = '0, e_data = '0;
  logic [AW-1:0] e_addr = '0;
  initial begin
    for (int i = 0; i < (1 << AW); i++) m_mem[i] = '0;
    for (int p = 0; p < 2; p++) begin m_ge[p] = 0; m_gv[p] = 0; m_val[p] = '0; end
  end

  always @(posedge clk) begin : model
    bit ce, ve, cw, vw;
    edge_n++;
    if (rst) begin
      m_gv[0] = 0; m_gv[1] = 0; m_wait = 0;
      e_cpu_ack = 0; e_vid_ack = 0; e_cpu_rdata = '0; e_vid_rdata = '0;
      e_clken = 0; e_wren = 0; e_addr = '0; e_data = '0;
    end else begin
      e_cpu_ack = m_gv[0] && (m_ge[0] + 2 == edge_n);
      e_vid_ack = m_gv[1] && (m_ge[1] + 2 == edge_n);
      if (e_cpu_ack) e_cpu_rdata = m_val[0];
      if (e_vid_ack) e_vid_rdata = m_val[1];
      ce = cpu_req && !(m_gv[0] && edge_n <= m_ge[0] + 3);
      ve = vid_req && !(m_gv[1] && edge_n <= m_ge[1] + 3);
      cw = ce && (!ve || m_wait == MW);
      vw = ve && !cw;
      if (!ce || cw) m_wait = 0;
      else if (m_wait < MW) m_wait++;
      e_clken = cw || vw;
      e_wren  = cw && cpu_we;
      if (cw) begin
        e_addr = cpu_addr; e_data = cpu_wdata;
        m_gv[0] = 1; m_ge[0] = edge_n;
        if (cpu_we) begin m_mem[cpu_addr] = cpu_wdata; m_val[0] = cpu_wdata; end
        else m_val[0] = m_mem[cpu_addr];
      end
      if (vw) begin
        e_addr = vid_addr;
        m_gv[1] = 1; m_ge[1] = edge_n; m_val[1] = m_mem[vid_addr];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    if (chk_en) begin
      check("m_cpu_ack",   32'(cpu_ack),     32'(e_cpu_ack));
      check("m_vid_ack",   32'(vid_ack),     32'(e_vid_ack));
      check("m_cpu_rdata", 32'(cpu_rdata),   32'(e_cpu_rdata));
      check("m_vid_rdata", 32'(vid_rdata),   32'(e_vid_rdata));
      check("m_clken",     32'(ram_clken),   32'(e_clken));
      check("m_wren",      32'(ram_wren),    32'(e_wren));
      check("m_addr",      32'(ram_address), 32'(e_addr));
      check("m_data",      32'(ram_data),    32'(e_data));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 0;
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (cpu_ack) got = 1;
    end
    check("cpu_ack_timeout", 32'(got), 32'd1);
    cpu_req = 1'b0;
  endtask

  task automatic rand_cpu(input int n);
    int idle;
    for (int k = 0; k < n; k++) begin
      bit got = 0;
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = AW'($urandom_range(0, 7)) | ($urandom_range(0, 1) ? 11'h7F8 : 11'h000);
      cpu_wdata = DW'($urandom);
      cpu_req   = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (cpu_ack) got = 1;
      end
      check("rnd_cpu_timeout", 32'(got), 32'd1);
      idle = $urandom_range(0, 3);
      if (idle > 0) begin cpu_req = 1'b0; cyc(idle); end
    end
    cpu_req = 1'b0;
  endtask

  task automatic rand_vid(input int n);
    int idle;
    for (int k = 0; k < n; k++) begin
      bit got = 0;
      vid_addr = AW'($urandom_range(0, 7)) | ($urandom_range(0, 1) ? 11'h7F8 : 11'h000);
      vid_req  = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (vid_ack) got = 1;
      end
      check("rnd_vid_timeout", 32'(got), 32'd1);
      idle = $urandom_range(0, 2);
      if (idle > 0) begin vid_req = 1'b0; cyc(idle); end
    end
    vid_req = 1'b0;
  endtask

  initial begin
    cyc(1);
    chk_en = 1'b1;
    cyc(2);
    // Reset state
    check("rst_cpu_ack", 32'(cpu_ack), 0);
    check("rst_vid_ack", 32'(vid_ack), 0);
    check("rst_clken", 32'(ram_clken), 0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 0);
    rst = 1'b0;
    cyc(2);

    // Single CPU write 0x123 <= 0xA5
    cpu_we = 1'b1; cpu_addr = 11'h123; cpu_wdata = 8'hA5; cpu_req = 1'b1;
    cyc(1);
    check("wr_clken", 32'(ram_clken), 1);
    check("wr_wren", 32'(ram_wren), 1);
    check("wr_addr", 32'(ram_address), 32'h123);
    cyc(1);
    check("wr_ack_early", 32'(cpu_ack), 0);
    cyc(1);
    check("wr_ack", 32'(cpu_ack), 1);
    check("wr_rdata", 32'(cpu_rdata), 32'hA5);
    cpu_req = 1'b0;
    cyc(2);

    // Readback of 0x123
    cpu_we = 1'b0; cpu_req = 1'b1;
    cyc(1);
    check("rd_clken", 32'(ram_clken), 1);
    check("rd_wren", 32'(ram_wren), 0);
    cyc(2);
    check("rd_ack", 32'(cpu_ack), 1);
    check("rd_rdata", 32'(cpu_rdata), 32'hA5);
    check("rd_vid_ack", 32'(vid_ack), 0);
    cpu_req = 1'b0;
    cyc(2);

    // Simultaneous video read 0x010 and CPU read 0x123
    cpu_access(1'b1, 11'h010, 8'h5A);
    cyc(2);
    vid_addr = 11'h010; vid_req = 1'b1;
    cpu_we = 1'b0; cpu_addr = 11'h123; cpu_req = 1'b1;
    cyc(1);
    check("sim_g1_addr", 32'(ram_address), 32'h010);
    cyc(1);
    check("sim_g2_clken", 32'(ram_clken), 1);
    check("sim_g2_addr", 32'(ram_address), 32'h123);
    cyc(1);
    check("sim_vid_ack", 32'(vid_ack), 1);
    check("sim_vid_rdata", 32'(vid_rdata), 32'h5A);
    check("sim_cpu_ack_early", 32'(cpu_ack), 0);
    vid_req = 1'b0;
    cyc(1);
    check("sim_cpu_ack", 32'(cpu_ack), 1);
    check("sim_cpu_rdata", 32'(cpu_rdata), 32'hA5);
    check("sim_vid_ack_off", 32'(vid_ack), 0);
    cpu_req = 1'b0;
    cyc(2);

    // Reset in the grant cycle of a CPU read
    cpu_we = 1'b0; cpu_addr = 11'h123; cpu_req = 1'b1;
    cyc(1);
    check("rm_clken", 32'(ram_clken), 1);
    rst = 1'b1; cpu_req = 1'b0;
    cyc(1);
    check("rm_cpu_ack", 32'(cpu_ack), 0);
    check("rm_clken0", 32'(ram_clken), 0);
    check("rm_addr0", 32'(ram_address), 0);
    check("rm_cpu_rdata0", 32'(cpu_rdata), 0);
    check("rm_vid_rdata0", 32'(vid_rdata), 0);
    rst = 1'b0;
    cyc(1);
    check("rm_no_ack", 32'(cpu_ack), 0);
    cpu_req = 1'b1;
    cyc(3);
    check("rm_new_ack", 32'(cpu_ack), 1);
    check("rm_new_rdata", 32'(cpu_rdata), 32'hA5);
    cpu_req = 1'b0;
    cyc(2);

    // Write-through followed by video read of the same address
    cpu_access(1'b1, 11'h200, 8'h3C);
    cyc(1);
    vid_addr = 11'h200; vid_req = 1'b1;
    cyc(3);
    check("wv_vid_ack", 32'(vid_ack), 1);
    check("wv_vid_rdata", 32'(vid_rdata), 32'h3C);
    vid_req = 1'b0;
    cyc(2);

    // Randomized contention, including back-to-back video requests
    fork
      rand_cpu(60);
      rand_vid(80);
    join
    cyc(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
